// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request channel, fixed-latency
// one-cycle response pulse, and a busy flag that stalls the CPU pipeline.
module dmem_responder #(
  parameter int DEPTH_WORDS = 16384,
  parameter int ADDR_W      = 14,
  parameter int LATENCY     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic        ready_en;
  logic        accept;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        cur_write;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_err;
  logic        enter_resp;

  // Zero contents at time 0 for simulation only; reset never touches them.
  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({32'h0, a} >= 64'(DEPTH_WORDS) * 64'd4);
  endfunction

  assign accept = req_valid && req_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Holds req_ready low until the first edge after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (accept) next_state = (LATENCY > 1) ? BUSY : RESP;
      BUSY: if (cnt == 4'd1) next_state = RESP;
      RESP: begin
        if (accept) next_state = (LATENCY > 1) ? BUSY : RESP;
        else        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = ready_en && (state != BUSY);
    resp_valid = (state == RESP);
    busy       = (state == BUSY);
    resp_err   = resp_valid && addr_err(addr_q);
    resp_rdata = resp_valid ? rdata_q : 32'h0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      cnt     <= CNT_LOAD;
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end else if (state == BUSY) begin
      cnt     <= cnt - 4'd1;
    end
  end

  // With a one-cycle latency the access commits on its own accept edge,
  // so the request lines are used directly instead of the latched copy.
  assign cur_write  = (LATENCY == 1) ? req_write : write_q;
  assign cur_addr   = (LATENCY == 1) ? req_addr  : addr_q;
  assign cur_wdata  = (LATENCY == 1) ? req_wdata : wdata_q;
  assign cur_err    = addr_err(cur_addr);
  assign enter_resp = (next_state == RESP);

  // NOTE: the storage array and its read register have no reset; reset would
  // force a huge flop array instead of a RAM, and resp_rdata is gated anyway.
  always_ff @(posedge clk) begin
    if (enter_resp) begin
      if (cur_write && !cur_err) mem[cur_addr[ADDR_W+1:2]] <= cur_wdata;
      rdata_q <= (!cur_write && !cur_err) ? mem[cur_addr[ADDR_W+1:2]] : 32'h0;
    end
  end

endmodule
